// File: rtl/tour_move_sequencer.sv
// Knight's-tour playback: turns each one-hot L-move into a vertical
// then a horizontal motion command, with UART pass-through when idle.
module tour_move_sequencer #(
    parameter int         NUM_MOVES = 24,
    parameter logic [7:0] RESP_ACK  = 8'hA5,
    parameter logic [7:0] RESP_POS  = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tour_start,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] indx_nxt;

    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic [3:0]        sq_x;
    logic [3:0]        sq_y;
    logic [15:0]       cmd_vert;
    logic [15:0]       cmd_horz;
    logic              last_move;

    // Ordered case: the lowest set bit wins on multi-hot input.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (1'b1)
            move[0]: begin dx = -3'sd1; dy =  3'sd2; end
            move[1]: begin dx =  3'sd1; dy =  3'sd2; end
            move[2]: begin dx = -3'sd2; dy =  3'sd1; end
            move[3]: begin dx = -3'sd2; dy = -3'sd1; end
            move[4]: begin dx = -3'sd1; dy = -3'sd2; end
            move[5]: begin dx =  3'sd1; dy = -3'sd2; end
            move[6]: begin dx =  3'sd2; dy =  3'sd1; end
            move[7]: begin dx =  3'sd2; dy = -3'sd1; end
            default: begin dx = 3'sd0; dy = 3'sd0; end
        endcase
    end

    assign sq_x = {1'b0, (dx < 0) ? 3'(-dx) : 3'(dx)};
    assign sq_y = {1'b0, (dy < 0) ? 3'(-dy) : 3'(dy)};

    assign cmd_vert = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, sq_y};
    assign cmd_horz = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, sq_x};

    assign last_move = (mv_indx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            state   <= state_nxt;
            mv_indx <= indx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        indx_nxt  = mv_indx;
        cmd       = cmd_vert;
        cmd_rdy   = 1'b0;
        resp      = RESP_POS;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_ACK;
                if (tour_start) begin
                    indx_nxt  = 5'd0;
                    state_nxt = VERT;
                end
            end
            VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy)
                    state_nxt = HOLD_V;
            end
            HOLD_V: begin
                if (send_resp)
                    state_nxt = HORZ;
            end
            HORZ: begin
                cmd     = cmd_horz;
                cmd_rdy = 1'b1;
                resp    = last_move ? RESP_ACK : RESP_POS;
                if (clr_cmd_rdy)
                    state_nxt = HOLD_H;
            end
            HOLD_H: begin
                cmd  = cmd_horz;
                resp = last_move ? RESP_ACK : RESP_POS;
                if (send_resp) begin
                    if (last_move) begin
                        indx_nxt  = 5'd0;
                        state_nxt = IDLE;
                    end else begin
                        indx_nxt  = mv_indx + 5'd1;
                        state_nxt = VERT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed bench for tour_move_sequencer: decode, handshake, full tour,
// ignored inputs and mid-tour reset.
module tb_tour_move_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tour_start;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cmds   = 0;

    logic [7:0]  mtab [24];
    logic [15:0] vtab [8];
    logic [15:0] htab [8];

    tour_move_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tour_start   (tour_start),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The solver's move port, indexed combinationally by mv_indx.
    always_comb move = (mv_indx < 5'd24) ? mtab[mv_indx] : 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in VERT; leaves it in the next move.
    task automatic play(input int idx, input logic [15:0] ev,
                        input logic [15:0] eh);
        #1;
        check($sformatf("v_idx%0d", idx), 32'(mv_indx), 32'(idx));
        check($sformatf("v_cmd%0d", idx), 32'(cmd), 32'(ev));
        check($sformatf("v_rdy%0d", idx), 32'(cmd_rdy), 32'd1);
        if (cmd_rdy) n_cmds++;
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        #1;
        check($sformatf("hv_rdy%0d", idx), 32'(cmd_rdy), 32'd0);
        check($sformatf("hv_resp%0d", idx), 32'(resp), 32'h5A);
        send_resp = 1'b1;
        cyc();
        send_resp = 1'b0;
        #1;
        check($sformatf("h_cmd%0d", idx), 32'(cmd), 32'(eh));
        check($sformatf("h_rdy%0d", idx), 32'(cmd_rdy), 32'd1);
        if (cmd_rdy) n_cmds++;
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        #1;
        check($sformatf("hh_rdy%0d", idx), 32'(cmd_rdy), 32'd0);
        check($sformatf("hh_resp%0d", idx), 32'(resp),
              (idx == 23) ? 32'hA5 : 32'h5A);
        send_resp = 1'b1;
        cyc();
        send_resp = 1'b0;
    endtask

    task automatic start_tour();
        tour_start = 1'b1;
        cyc();
        tour_start = 1'b0;
    endtask

    initial begin
        vtab = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                 16'h27F2, 16'h27F2, 16'h2001, 16'h27F1};
        htab = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};
        for (int i = 0; i < 24; i++) mtab[i] = 8'(1 << (i % 8));
        mtab[0] = 8'h01;
        mtab[1] = 8'h80;
        mtab[2] = 8'h06;

        rst_n        = 1'b0;
        tour_start   = 1'b0;
        cmd_UART     = 16'h2001;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        #2;
        check("rst_cmd", 32'(cmd), 32'h2001);
        check("rst_rdy", 32'(cmd_rdy), 32'd1);
        check("rst_resp", 32'(resp), 32'hA5);
        check("rst_idx", 32'(mv_indx), 32'd0);
        cyc();
        rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        cyc();
        #1;
        check("idle_rdy", 32'(cmd_rdy), 32'd0);

        // Moves 0..2: basic handshake and decode, lowest-bit priority.
        start_tour();
        play(0, 16'h2002, 16'h33F1);
        play(1, 16'h27F1, 16'h3BF2);
        play(2, 16'h2002, 16'h3BF1);

        // Move 3: clr+send together, with tour_start and UART noise.
        tour_start   = 1'b1;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        #1;
        check("noise_cmd", 32'(cmd), 32'h27F1);
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        #1;
        check("both_rdy", 32'(cmd_rdy), 32'd0);
        check("both_cmd", 32'(cmd), 32'h27F1);
        check("both_idx", 32'(mv_indx), 32'd3);
        cyc();
        #1;
        check("still_hold", 32'(cmd_rdy), 32'd0);
        tour_start = 1'b0;
        cmd_rdy_UART = 1'b0;
        send_resp = 1'b1;
        cyc();
        send_resp = 1'b0;
        #1;
        check("m3_horz", 32'(cmd), 32'h33F2);
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        cyc();
        send_resp = 1'b0;
        for (int i = 4; i < 10; i++) play(i, vtab[i % 8], htab[i % 8]);

        // Move 10: reset while in HOLD_H.
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        cyc();
        send_resp = 1'b0;
        clr_cmd_rdy = 1'b1;
        cyc();
        clr_cmd_rdy = 1'b0;
        #1;
        check("hh10_idx", 32'(mv_indx), 32'd10);
        check("hh10_rdy", 32'(cmd_rdy), 32'd0);
        cmd_UART = 16'h2001;
        cmd_rdy_UART = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mrst_idx", 32'(mv_indx), 32'd0);
        check("mrst_cmd", 32'(cmd), 32'h2001);
        check("mrst_rdy", 32'(cmd_rdy), 32'd1);
        check("mrst_resp", 32'(resp), 32'hA5);
        cyc();
        rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        cyc();

        // Full 24-move tour after the reset.
        n_cmds = 0;
        start_tour();
        play(0, 16'h2002, 16'h33F1);
        play(1, 16'h27F1, 16'h3BF2);
        play(2, 16'h2002, 16'h3BF1);
        for (int i = 3; i < 24; i++) play(i, vtab[i % 8], htab[i % 8]);
        #1;
        check("tour_cmds", 32'(n_cmds), 32'd48);
        check("end_idx", 32'(mv_indx), 32'd0);
        check("end_resp", 32'(resp), 32'hA5);
        cmd_UART = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        #1;
        check("end_cmd", 32'(cmd), 32'hBEEF);
        check("end_rdy", 32'(cmd_rdy), 32'd1);

        // Empty move decodes to zero-length legs.
        cmd_rdy_UART = 1'b0;
        mtab[0] = 8'h00;
        cyc();
        start_tour();
        #1;
        check("zero_v", 32'(cmd), 32'h27F0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
